ddr_wr_datapath_gen: RTL and testbench

DDR_WR_DATAPATH_GEN -- requirements
Module: ddr_wr_datapath_gen

---
 rtl/ddr_wr_datapath_gen_if.sv | 35 +++
 rtl/ddr_wr_datapath_gen.sv | 116 +++++++++++
 tb/tb_ddr_wr_datapath_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_datapath_gen_if.sv
// ddr_wr_datapath_gen_if: system write-word handshake and DRAM-side DQ/DM/DQS signals.
// The slave modport is the datapath; the master modport is whoever drives commands and data.
interface ddr_wr_datapath_gen_if #(
   parameter int DQ_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4
);
   logic                        wr_cmd;
   logic [2:0]                  wr_lat;
   logic                        sys_wvalid;
   logic                        sys_wready;
   logic [2*DQ_WIDTH-1:0]       sys_wdata;
   logic [1:0]                  sys_wmask;
   logic [DQ_WIDTH-1:0]         dq_rise;
   logic [DQ_WIDTH-1:0]         dq_fall;
   logic                        dm_rise;
   logic                        dm_fall;
   logic                        dqs_rise;
   logic                        dqs_fall;
   logic                        dq_oe;
   logic                        dqs_oe;
   logic                        busy;
   logic                        cmd_reject;
   logic                        underrun;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   modport master (
      output wr_cmd, wr_lat, sys_wvalid, sys_wdata, sys_wmask,
      input  sys_wready, dq_rise, dq_fall, dm_rise, dm_fall, dqs_rise, dqs_fall,
             dq_oe, dqs_oe, busy, cmd_reject, underrun, fifo_level
   );
   modport slave (
      input  wr_cmd, wr_lat, sys_wvalid, sys_wdata, sys_wmask,
      output sys_wready, dq_rise, dq_fall, dm_rise, dm_fall, dqs_rise, dqs_fall,
             dq_oe, dqs_oe, busy, cmd_reject, underrun, fifo_level
   );
endinterface

// File: rtl/ddr_wr_datapath_gen.sv
// ddr_wr_datapath_gen: write-data FIFO plus burst sequencer emitting two beats per clock
// with preamble/postamble DQS framing; every DRAM-side output comes straight from a flop.
module ddr_wr_datapath_gen #(
   parameter int DQ_WIDTH   = 8,
   parameter int BURST_LEN  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   ddr_wr_datapath_gen_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = 2*DQ_WIDTH + 2;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [2:0] HM1 = 3'(BURST_LEN/2 - 1);
   typedef enum logic [2:0] {IDLE, LATENCY, PREAMBLE, DATA, POSTAMBLE} state_t;
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [WW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] lvl_q, lvl_d;
   logic [WW-1:0] head;
   logic push, pop, in_data;
   logic [DQ_WIDTH-1:0] dq_rise_q, dq_rise_d, dq_fall_q, dq_fall_d;
   logic dm_rise_q, dm_rise_d, dm_fall_q, dm_fall_d, dqs_rise_q, dqs_rise_d;
   logic dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d, busy_q, busy_d;
   logic reject_q, reject_d, underrun_q, underrun_d;
   // Outputs are computed from the state being entered so they line up with it after the edge.
   assign in_data = state_d == DATA;
   assign push    = bus.sys_wvalid && lvl_q != FULL;
   assign pop     = in_data && lvl_q != '0;
   assign head    = mem_q[rp_q];
   assign lvl_d   = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         lvl_q      <= '0;
         dq_rise_q  <= '0;
         dq_fall_q  <= '0;
         dm_rise_q  <= 1'b0;
         dm_fall_q  <= 1'b0;
         dqs_rise_q <= 1'b0;
         dq_oe_q    <= 1'b0;
         dqs_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         reject_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wp_q       <= push ? wp_q + AW'(1) : wp_q;
         rp_q       <= pop ? rp_q + AW'(1) : rp_q;
         lvl_q      <= lvl_d;
         dq_rise_q  <= dq_rise_d;
         dq_fall_q  <= dq_fall_d;
         dm_rise_q  <= dm_rise_d;
         dm_fall_q  <= dm_fall_d;
         dqs_rise_q <= dqs_rise_d;
         dq_oe_q    <= dq_oe_d;
         dqs_oe_q   <= dqs_oe_d;
         busy_q     <= busy_d;
         reject_q   <= reject_d;
         underrun_q <= underrun_d;
      end
   end
   always_ff @(posedge clk)
      if (push) mem_q[wp_q] <= {bus.sys_wdata, bus.sys_wmask};
   // cnt holds remaining clocks minus one, so latency L spends L-1 clocks in LATENCY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:      if (bus.wr_cmd) begin
                       state_d = LATENCY;
                       cnt_d   = bus.wr_lat < 3'd2 ? 3'd0 : bus.wr_lat - 3'd2;
                    end
         LATENCY:   if (cnt_q == 3'd0) state_d = PREAMBLE;
                    else cnt_d = cnt_q - 3'd1;
         PREAMBLE:  begin
                       state_d = DATA;
                       cnt_d   = HM1;
                    end
         DATA:      if (cnt_q == 3'd0) state_d = POSTAMBLE;
                    else cnt_d = cnt_q - 3'd1;
         default:   state_d = IDLE;
      endcase
   end
   always_comb begin
      dq_oe_d    = in_data;
      dqs_rise_d = in_data;
      dqs_oe_d   = state_d inside {PREAMBLE, DATA, POSTAMBLE};
      busy_d     = state_d != IDLE;
      reject_d   = bus.wr_cmd && state_q != IDLE;
      underrun_d = in_data && !pop;
      dq_rise_d  = pop ? head[WW-1 -: DQ_WIDTH] : '0;
      dq_fall_d  = pop ? head[DQ_WIDTH+1 -: DQ_WIDTH] : '0;
      dm_rise_d  = in_data && (!pop || head[1]);
      dm_fall_d  = in_data && (!pop || head[0]);
   end
   assign bus.sys_wready = lvl_q != FULL;
   assign bus.fifo_level = lvl_q;
   assign bus.dq_rise    = dq_rise_q;
   assign bus.dq_fall    = dq_fall_q;
   assign bus.dm_rise    = dm_rise_q;
   assign bus.dm_fall    = dm_fall_q;
   assign bus.dqs_rise   = dqs_rise_q;
   assign bus.dqs_fall   = 1'b0;
   assign bus.dq_oe      = dq_oe_q;
   assign bus.dqs_oe     = dqs_oe_q;
   assign bus.busy       = busy_q;
   assign bus.cmd_reject = reject_q;
   assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_ddr_wr_datapath_gen.sv
// tb_ddr_wr_datapath_gen: directed and random scenarios checked against a window/queue model
// that predicts every output from the accepted-command edge number and a word queue.
module tb_ddr_wr_datapath_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ddr_wr_datapath_gen_if #(.DQ_WIDTH(8), .FIFO_DEPTH(4)) bus ();
   ddr_wr_datapath_gen #(.DQ_WIDTH(8), .BURST_LEN(4), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   localparam int H = 2;
   int errors = 0;
   int checks = 0;
   int k = 0;
   int e0 = -1000;
   int lat = 2;
   logic [17:0] q[$];
   logic [28:0] exp_v;
   function automatic logic [28:0] obs();
      return {bus.dq_rise, bus.dq_fall, bus.dm_rise, bus.dm_fall, bus.dqs_rise, bus.dqs_fall,
              bus.dq_oe, bus.dqs_oe, bus.busy, bus.cmd_reject, bus.underrun, bus.fifo_level, bus.sys_wready};
   endfunction
   // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
   task automatic step(input logic cmd, input logic [2:0] wl, input logic v, input logic [15:0] d, input logic [1:0] m);
      int sz;
      logic [17:0] w;
      logic data, und, rej;
      bus.wr_cmd = cmd; bus.wr_lat = wl; bus.sys_wvalid = v; bus.sys_wdata = d; bus.sys_wmask = m;
      @(posedge clk);
      k++;
      rej = 1'b0;
      if (cmd) begin
         if (k >= e0 + 1 && k <= e0 + lat + H + 1) rej = 1'b1;
         else begin
            e0 = k;
            lat = (wl < 3'd2) ? 2 : int'(wl);
         end
      end
      data = k >= e0 + lat && k <= e0 + lat + H - 1;
      sz = q.size();
      w = 18'h0;
      und = 1'b0;
      if (data) begin
         if (sz > 0) w = q.pop_front();
         else begin
            und = 1'b1;
            w = 18'h3;
         end
      end
      if (v && sz < 4) q.push_back({d, m});
      exp_v = {w[17:2], w[1], w[0], data, 1'b0, data, k >= e0 + lat - 1 && k <= e0 + lat + H,
               k >= e0 && k <= e0 + lat + H, rej, und, 3'(q.size()), q.size() != 4};
      #1;
   endtask
   task automatic model_reset();
      q.delete();
      e0 = -1000;
   endtask
   task automatic test_reset();
      #1 rst = 1'b0;
      model_reset();
      #1;
      if (obs() !== 29'h1) begin errors++; $display("FAIL reset_state got=%h want=%h", obs(), 29'h1); end
      checks++;
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd0, 1'b0, 16'h0, 2'b00);
         if (obs() !== exp_v) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
      end
   endtask
   task automatic test_directed();
      int und = 0;
      for (int i = -2; i <= 6; i++) begin
         if (i == -2) step(1'b0, 3'd0, 1'b1, 16'hA55A, 2'b00);
         else if (i == -1) step(1'b0, 3'd0, 1'b1, 16'h1234, 2'b10);
         else step(i == 0, 3'd3, 1'b0, 16'h0, 2'b00);
         if (obs() !== exp_v) begin errors++; $display("FAIL directed cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
         und += int'(bus.underrun);
         if (i >= 0) begin
            if (bus.dqs_oe !== (i >= 2 && i <= 5) || bus.dq_oe !== (i == 3 || i == 4)) begin
               errors++; $display("FAIL directed_oe E%0d got dqs_oe=%b dq_oe=%b", i, bus.dqs_oe, bus.dq_oe);
            end
            checks++;
         end
         if (i == 3) begin
            if ({bus.dq_rise, bus.dq_fall, bus.dm_rise, bus.dm_fall} !== 18'h2_9568) begin
               errors++; $display("FAIL directed_beat1 got=%h %h %b%b want=a5 5a 00", bus.dq_rise, bus.dq_fall, bus.dm_rise, bus.dm_fall);
            end
            checks++;
         end
         if (i == 4) begin
            if ({bus.dq_rise, bus.dq_fall, bus.dm_rise, bus.dm_fall} !== {16'h1234, 2'b10}) begin
               errors++; $display("FAIL directed_beat2 got=%h %h %b%b want=12 34 10", bus.dq_rise, bus.dq_fall, bus.dm_rise, bus.dm_fall);
            end
            checks++;
         end
      end
      if (und != 0) begin errors++; $display("FAIL directed_underrun got=%0d want=0", und); end
      checks++;
   endtask
   task automatic test_underrun();
      int und = 0;
      step(1'b0, 3'd0, 1'b1, 16'($urandom), 2'($urandom));
      for (int i = 0; i <= 6; i++) begin
         step(i == 0, 3'd3, 1'b0, 16'h0, 2'b00);
         if (obs() !== exp_v) begin errors++; $display("FAIL underrun cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
         und += int'(bus.underrun);
      end
      if (und != 1 || bus.fifo_level !== 3'd0) begin
         errors++; $display("FAIL underrun_count got=%0d lvl=%0d want=1 lvl=0", und, bus.fifo_level);
      end
      checks++;
   endtask
   task automatic test_full();
      logic pending = 1'b1;
      logic rdy;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 3'd0, 1'b1, 16'h1000 + 16'(i), 2'(i));
         if (obs() !== exp_v) begin errors++; $display("FAIL full_fill cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
      end
      for (int i = 0; i < 11; i++) begin
         rdy = bus.sys_wready;
         step(i == 3, 3'd2, pending, 16'hBEEF, 2'b01);
         if (pending && rdy) pending = 1'b0;
         if (obs() !== exp_v) begin errors++; $display("FAIL full_hold cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
         if (i < 3) begin
            if (bus.fifo_level !== 3'd4 || bus.sys_wready !== 1'b0) begin
               errors++; $display("FAIL full_flag lvl=%0d rdy=%b want lvl=4 rdy=0", bus.fifo_level, bus.sys_wready);
            end
            checks++;
         end
      end
      if (bus.fifo_level !== 3'd3 || pending) begin
         errors++; $display("FAIL full_end lvl=%0d pending=%b want lvl=3 pending=0", bus.fifo_level, pending);
      end
      checks++;
   endtask
   task automatic test_back_to_back();
      int rej = 0;
      int oe = 0;
      for (int i = 0; i < 10; i++) begin
         step(i < 2, i == 0 ? 3'd3 : 3'd2, 1'b0, 16'h0, 2'b00);
         if (obs() !== exp_v) begin errors++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
         rej += int'(bus.cmd_reject);
         oe += int'(bus.dq_oe);
      end
      if (rej != 1 || oe != 2) begin
         errors++; $display("FAIL back_to_back_count rej=%0d dq_oe=%0d want rej=1 dq_oe=2", rej, oe);
      end
      checks++;
   endtask
   task automatic test_lat0();
      logic [6:0] dq_p, dqs_p;
      for (int r = 0; r < 2; r++) begin
         dq_p = '0;
         dqs_p = '0;
         for (int i = 0; i <= 6; i++) begin
            step(i == 0, r == 0 ? 3'd0 : 3'd2, 1'b0, 16'h0, 2'b00);
            if (obs() !== exp_v) begin errors++; $display("FAIL lat0 cyc=%0d got=%h want=%h", k, obs(), exp_v); end
            checks++;
            dq_p[i] = bus.dq_oe;
            dqs_p[i] = bus.dqs_oe;
         end
         if (dq_p !== 7'b0001100 || dqs_p !== 7'b0011110) begin
            errors++; $display("FAIL lat0_window lat=%0d dq_oe=%b dqs_oe=%b want 0001100 0011110", r * 2, dq_p, dqs_p);
         end
         checks++;
      end
   endtask
   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         step(i == 2, 3'd2, i < 2, 16'hC0DE + 16'(i), 2'b00);
         if (obs() !== exp_v) begin errors++; $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
      end
      if (bus.dq_oe !== 1'b1) begin errors++; $display("FAIL reset_mid_data got dq_oe=%b want 1", bus.dq_oe); end
      checks++;
      #2 rst = 1'b0;
      model_reset();
      #1;
      if (obs() !== 29'h1) begin errors++; $display("FAIL reset_mid_async got=%h want=%h", obs(), 29'h1); end
      checks++;
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd0, i == 0, 16'h7777, 2'b11);
         if (obs() !== exp_v) begin errors++; $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 5,
              16'($urandom), 2'($urandom));
         if (obs() !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs(), exp_v); end
         checks++;
      end
   endtask
   initial begin
      bus.wr_cmd = 1'b0;
      bus.wr_lat = 3'd0;
      bus.sys_wvalid = 1'b0;
      bus.sys_wdata = '0;
      bus.sys_wmask = '0;
      test_reset();
      test_directed();
      test_underrun();
      test_full();
      test_back_to_back();
      test_lat0();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
